// File: rtl/header_pkg.sv
`default_nettype none
// ============================================================================
// Module      : header_pkg
// Description : Shared header-entry layout, frame limits and the extractor
//               state encoding. The switch-side header decode uses it too.
// Revision    : 1.0 - initial release
// ============================================================================
package header_pkg;

    localparam int LEN_W     = 11;
    localparam int MIN_LEN   = 14;
    localparam int HDR_BYTES = 12;
    localparam int HDR_W     = 128;
    localparam int MAC_W     = 48;

    localparam int HDR_PORT_MSB  = 115;
    localparam int HDR_PORT_LSB  = 112;
    localparam int HDR_LEN_MSB   = 111;
    localparam int HDR_LEN_LSB   = 101;
    localparam int HDR_BCAST_BIT = 100;
    localparam int HDR_MCAST_BIT = 99;
    localparam int HDR_DA_MSB    = 95;
    localparam int HDR_DA_LSB    = 48;
    localparam int HDR_SA_MSB    = 47;
    localparam int HDR_SA_LSB    = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_BODY   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DROP   = 3'd4
    } state_t;

    // mac carries DA in its upper 48 bits and SA in its lower 48 bits.
    function automatic logic [HDR_W-1:0] pack_header(
        input logic [3:0]       port,
        input logic [LEN_W-1:0] len,
        input logic             bcast,
        input logic             mcast,
        input logic [95:0]      mac
    );
        logic [HDR_W-1:0] h;
        h = '0;
        h[HDR_PORT_MSB:HDR_PORT_LSB] = port;
        h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        h[HDR_BCAST_BIT]             = bcast;
        h[HDR_MCAST_BIT]             = mcast;
        h[HDR_DA_MSB:HDR_DA_LSB]     = mac[95:48];
        h[HDR_SA_MSB:HDR_SA_LSB]     = mac[47:0];
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_flag_decode.sv
`default_nettype none
// ============================================================================
// Module      : mac_flag_decode
// Description : Broadcast / multicast classification of a destination MAC.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_flag_decode
    import header_pkg::*;
(
    input  logic [MAC_W-1:0] da_i,
    output logic             bcast_o,
    output logic             mcast_o
);

    // Bit 40 is the I/G bit of the first wire byte.
    assign bcast_o = &da_i;
    assign mcast_o = da_i[40] & ~bcast_o;

endmodule
`default_nettype wire

// File: rtl/header_extractor.sv
`default_nettype none
// ============================================================================
// Module      : header_extractor
// Description : Captures DA/SA and length of each received frame and writes a
//               128-bit header entry; bad, oversized or unwritable frames are
//               counted as drops.
// Revision    : 1.0 - initial release
// ============================================================================
module header_extractor
    import header_pkg::*;
#(
    parameter logic [3:0] PORT_ID = 4'd0,
    parameter int         MAX_LEN = 1522
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         rx_sof,
    input  logic         rx_eof,
    input  logic         rx_err,
    output logic [127:0] h_fifo_din,
    output logic         h_fifo_wren,
    input  logic         h_fifo_full,
    output logic [15:0]  drop_cnt
);

    state_t             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [95:0]        mac_q;
    logic [HDR_W-1:0]   din_q;
    logic [15:0]        drop_q;

    logic [LEN_W-1:0]   w_len_inc;
    logic [31:0]        w_len_ext;
    logic               w_frame_ok;
    logic               w_in_frame;
    logic               w_drop;
    logic               w_bcast;
    logic               w_mcast;

    assign w_len_inc  = (len_q == '1) ? len_q : len_q + LEN_W'(1);
    assign w_len_ext  = 32'(w_len_inc);
    assign w_frame_ok = !rx_err && (w_len_ext >= 32'(MIN_LEN)) && (w_len_ext <= 32'(MAX_LEN));
    assign w_in_frame = (state_q == ST_HDR) || (state_q == ST_BODY) || (state_q == ST_DROP);

    // A new SOF aborts any open frame; an EOF drops unless it completes a good frame in BODY.
    assign w_drop = ((state_q == ST_COMMIT) && h_fifo_full)
                  || (rx_valid && w_in_frame
                      && (rx_sof || (rx_eof && !((state_q == ST_BODY) && w_frame_ok))));

    mac_flag_decode u_flags (
        .da_i    (mac_q[95:48]),
        .bcast_o (w_bcast),
        .mcast_o (w_mcast)
    );

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            mac_q   <= '0;
            din_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && rx_sof) begin
                        state_q <= ST_HDR;
                        len_q   <= LEN_W'(1);
                        mac_q   <= {88'd0, rx_data};
                    end
                end
                ST_COMMIT: begin
                    if (rx_valid && rx_sof) begin
                        state_q <= ST_HDR;
                        len_q   <= LEN_W'(1);
                        mac_q   <= {88'd0, rx_data};
                    end else begin
                        state_q <= ST_IDLE;
                        len_q   <= '0;
                    end
                end
                ST_HDR, ST_BODY, ST_DROP: begin
                    if (rx_valid) begin
                        if (rx_sof) begin
                            state_q <= ST_HDR;
                            len_q   <= LEN_W'(1);
                            mac_q   <= {88'd0, rx_data};
                        end else begin
                            len_q <= w_len_inc;
                            case (state_q)
                                ST_HDR: begin
                                    mac_q <= {mac_q[87:0], rx_data};
                                    if (rx_eof)
                                        state_q <= ST_IDLE;
                                    else if (len_q == LEN_W'(HDR_BYTES - 1))
                                        state_q <= ST_BODY;
                                end
                                ST_BODY: begin
                                    if (rx_eof) begin
                                        if (w_frame_ok) begin
                                            state_q <= ST_COMMIT;
                                            din_q   <= pack_header(PORT_ID, w_len_inc,
                                                                   w_bcast, w_mcast, mac_q);
                                        end else begin
                                            state_q <= ST_IDLE;
                                        end
                                    end else if (w_len_ext > 32'(MAX_LEN)) begin
                                        state_q <= ST_DROP;
                                    end
                                end
                                default: begin
                                    if (rx_eof)
                                        state_q <= ST_IDLE;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    len_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n)
            drop_q <= '0;
        else if (w_drop && (drop_q != 16'hFFFF))
            drop_q <= drop_q + 16'd1;
    end

    // COMMIT always exits after one cycle, so the strobe cannot repeat.
    assign h_fifo_wren = (state_q == ST_COMMIT) && !h_fifo_full;
    assign h_fifo_din  = din_q;
    assign drop_cnt    = drop_q;

endmodule
`default_nettype wire

// File: doc/header_extractor.md
HEADER_EXTRACTOR -- requirements
Module: header_extractor

Interface
REQ-001 SHALL have parameter PORT_ID, default 4'd0, ingress port number stamped into every header entry.
REQ-002 SHALL have parameter MAX_LEN, default 1522, largest accepted frame length in bytes, FCS included.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port arst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port rx_data, input, 8 bits: receive byte from the MAC RX path.
REQ-006 SHALL have port rx_valid, input, 1 bit: rx_data is valid this cycle; there is no backpressure.
REQ-007 SHALL have port rx_sof, input, 1 bit: first byte of a frame; qualified by rx_valid.
REQ-008 SHALL have port rx_eof, input, 1 bit: last byte of a frame; qualified by rx_valid.
REQ-009 SHALL have port rx_err, input, 1 bit: frame error (FCS or PHY error); sampled only with rx_eof.
REQ-010 SHALL have port h_fifo_din, output, 128 bits: header entry written to the header FIFO.
REQ-011 SHALL have port h_fifo_wren, output, 1 bit: single-cycle header FIFO write strobe.
REQ-012 SHALL have port h_fifo_full, input, 1 bit: the header FIFO cannot accept a write.
REQ-013 SHALL have port drop_cnt, output, 16 bits: saturating count of dropped frames.

Function
REQ-014 SHALL format h_fifo_din as follows:
- [127:116] = 0
- [115:112] = PORT_ID
- [111:101] = frame length, 11 bits
- [100] = broadcast
- [99] = multicast
- [98:96] = 0
- [95:48] = destination MAC
- [47:0] = source MAC
REQ-015 SHALL store MAC addresses with the first wire byte in the most significant byte.
REQ-016 SHALL implement states IDLE, HDR, BODY, COMMIT and DROP.
REQ-017 SHALL treat rx_valid low as a stall in every state: no state change, no count change.
REQ-018 IDLE: rx_valid and rx_sof SHALL capture byte 0 into the destination MAC, set length=1 and go to HDR; bytes without rx_sof SHALL be ignored.
REQ-019 HDR: SHALL capture bytes 1..11 into the destination and source MAC, then go to BODY after byte 11.
REQ-020 BODY: SHALL increment the length on each valid byte; the length counter SHALL saturate at 2047.
REQ-021 SHALL use the same length counter in every state, counting every valid byte of the frame including FCS.
REQ-022 On a byte with rx_eof, the frame SHALL go to COMMIT only if all of these hold:
- no rx_err
- length (including that byte) is between 14 and MAX_LEN
Otherwise the frame SHALL be dropped and the block SHALL return to IDLE.
REQ-023 An rx_eof arriving in HDR SHALL count as a runt and SHALL be dropped.
REQ-024 A length exceeding MAX_LEN before eof SHALL move the block to DROP; DROP SHALL ignore bytes until rx_eof, then count one drop and return to IDLE.
REQ-025 COMMIT lasts exactly one cycle. If h_fifo_full=0, h_fifo_wren SHALL be 1 with h_fifo_din valid; if h_fifo_full=1, wren SHALL stay 0 and one drop SHALL be counted.
REQ-026 Latency: eof byte accepted in cycle N -> h_fifo_wren in cycle N+1.
REQ-027 A valid rx_sof byte in COMMIT SHALL be accepted as byte 0 of the next frame, with transition to HDR.
REQ-028 A valid rx_sof in HDR, BODY or DROP SHALL abort the current frame with one drop counted, and SHALL restart capture with that byte as byte 0.
REQ-029 Flags:
- broadcast = (destination == 48'hFFFF_FFFF_FFFF)
- multicast = destination bit 40 (I/G bit of the first byte) and not broadcast
REQ-030 drop_cnt SHALL saturate at 16'hFFFF, and SHALL increment at most once per cycle.
REQ-031 h_fifo_wren SHALL never be high for two consecutive cycles.

Reset
REQ-032 arst_n=0 at a clock edge SHALL force all of the following:
- state to IDLE
- h_fifo_wren=0
- h_fifo_din=0
- drop_cnt=0
- length=0
REQ-033 Reset mid-frame SHALL discard the frame without a write or a drop count; after release, bytes SHALL be ignored until the next rx_sof.

Structure
REQ-034 Package header_pkg SHALL hold the header field bit positions, MIN_LEN=14, LEN_W=11 and the state enumeration; the MAC_SWITCH header decode SHALL use the same package.
REQ-035 One sub-module is natural: mac_flag_decode, combinational, producing broadcast and multicast from the 48-bit destination MAC.

Verification
REQ-036 64-byte frame, DA=00:11:22:33:44:55, SA=66:77:88:99:AA:BB, no error -> one wren one cycle after eof, with:
- din[95:48]=48'h001122334455
- din[47:0]=48'h66778899AABB
- length=64, bcast=0, mcast=0
REQ-037 Frame with DA=FF:FF:FF:FF:FF:FF -> bcast=1, mcast=0; frame with DA=01:00:5E:00:00:01 -> bcast=0, mcast=1.
REQ-038 10-byte runt; 64-byte frame with rx_err at eof; 1600-byte giant -> no wren for any of them and drop_cnt=3.
REQ-039 h_fifo_full=1 during the COMMIT cycle -> no wren and drop_cnt increments by 1; the next frame with full=0 is written normally.
REQ-040 Back-to-back frames with rx_sof in the COMMIT cycle; rx_valid gaps mid-frame; arst_n low mid-frame -> both back-to-back frames written with correct lengths, gaps do not alter the length, and the reset frame produces no write and no drop.
